conv_layer_driver: RTL and testbench
====================================

Name: conv_layer_driver

Overview:
Initiator for the single-layer CNN input interface and reader of its result interface. Holds a 7-pixel 4-bit image and a 3-tap 4-bit filter, then streams the 15 (pixel, tap) pairs into the layer under Start. It pulses ReadEn for the 5 triple-sums and captures ConvResult into indexed result beats, so one 1-D convolution of 5 outputs is run per go pulse.

Parameters:
RESULT_LAT, 2, cycles from a ReadEn-high cycle to its ConvResult being valid at the layer output
GAP_CYC, 1, idle cycles between the last Start cycle and the first ReadEn cycle (range 1..3)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
img_wr_en  in  1  write image buffer entry
img_wr_addr  in  3  image index 0..6; 7 ignored
img_wr_data  in  4  unsigned pixel
flt_wr_en  in  1  write filter buffer entry
flt_wr_addr  in  2  tap index 0..2; 3 ignored
flt_wr_data  in  4  unsigned tap
go  in  1  start one run (single-cycle pulse)
busy  out  1  high from the cycle after accepted go until done
done  out  1  one-cycle pulse after last result beat
Start  out  1  to layer: product write strobe
Image  out  4  to layer: pixel operand
Filter  out  4  to layer: tap operand
ReadEn  out  1  to layer: triple-sum read strobe
ConvResult  in  10  from layer: unsigned sum of 3 products
res_valid  out  1  result beat valid (one cycle)
res_idx  out  3  output index 0..4
res_data  out  10  captured ConvResult

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, Start, ReadEn, res_valid = 0; Image, Filter, res_idx, res_data = 0; buffers cleared to 0. Reset mid-run aborts immediately; Start/ReadEn drop in the same cycle reset is asserted.
- Buffer writes are accepted only in IDLE; ignored while busy. An out-of-range address is ignored.
- FSM: IDLE -go-> STREAM (15 cyc) -> GAP (GAP_CYC cyc) -> READ (5 cyc) -> DRAIN (RESULT_LAT cyc) -> DONE (1 cyc, done=1) -> IDLE.
- go while busy is ignored. A go arriving in the DONE cycle is also ignored.
- STREAM: counters k=0..4 (outer), j=0..2 (inner). Start=1, Image=img[k+j], Filter=flt[j], all registered. There are exactly 15 consecutive Start cycles, so the layer write counter returns to 0.
- READ: ReadEn=1 for exactly 5 consecutive cycles. Other outputs to the layer are held at 0 and Start=0.
- Capture: a RESULT_LAT-deep valid/index delay line tracks ReadEn. When it emits, register res_valid=1, res_idx=index, res_data=ConvResult. Beats are in order 0..4, one per cycle, and end before DONE.
- Width: products ≤225, sums ≤675; 10 bits with no overflow, no truncation.
- busy stays 1 through DRAIN. The done pulse is coincident with busy falling.

Optional Feature:
CONV_SELFCHECK_EN
- Defined: adds output res_err (1 bit). The block computes expected = img[k]*flt[0] + img[k+1]*flt[1] + img[k+2]*flt[2] for each beat. res_err=1 with res_valid on mismatch and is 0 otherwise. A sticky err_seen is cleared on go.
- Undefined: no port and no checker logic; behaviour is otherwise identical.

Decomposition:
- Package conv_drv_pkg holds: N_PIX=7, N_TAP=3, N_OUT=5, N_PROD=15, PIX_W=4, RES_W=10, the state enum (IDLE, STREAM, GAP, READ, DRAIN, DONE), and the expected-sum function for the checker.
- One sub-module, conv_pair_seq, holds the k/j counters and the Image/Filter mux.
- FSM and capture stay in the top.

Test Plan:
- img=1..7, flt=1,2,3, go: Image seq 1,2,3,2,3,4,…,5,6,7 and Filter 1,2,3×5 over 15 Start cycles. Results idx0..4 = 14,20,26,32,38, then done.
- img all 15, flt all 15: every res_data = 675; with CONV_SELFCHECK_EN, res_err stays 0.
- go pulsed again during STREAM and buffer writes while busy: ignored; the second run starts only after IDLE and uses the old buffers.
- rst_n low mid-STREAM (cycle 7): Start=0 immediately. After release, a new run gives correct results 14..38.
- RESULT_LAT=3, GAP_CYC=2: ReadEn starts 2 cycles after the last Start, and the first res_valid comes 3 cycles after the first ReadEn.
- CONV_SELFCHECK_EN with the layer model forcing ConvResult+1 on idx2: res_err=1 only on beat 2, and err_seen is set.

Source files
------------

// File: rtl/conv_drv_pkg.sv
// Shared constants, FSM state type and the reference triple-sum for the conv layer driver.
package conv_drv_pkg;

  localparam int unsigned N_PIX  = 7;
  localparam int unsigned N_TAP  = 3;
  localparam int unsigned N_OUT  = 5;
  localparam int unsigned N_PROD = 15;
  localparam int unsigned PIX_W  = 4;
  localparam int unsigned RES_W  = 10;

  typedef enum logic [2:0] {
    StIdle,
    StStream,
    StGap,
    StRead,
    StDrain,
    StDone
  } state_e;

  function automatic logic [RES_W-1:0] exp_sum(input logic [PIX_W-1:0] p0, input logic [PIX_W-1:0] p1,
                                                input logic [PIX_W-1:0] p2, input logic [PIX_W-1:0] t0,
                                                input logic [PIX_W-1:0] t1, input logic [PIX_W-1:0] t2);
    return RES_W'(p0) * RES_W'(t0) + RES_W'(p1) * RES_W'(t1) + RES_W'(p2) * RES_W'(t2);
  endfunction

endpackage

// File: rtl/conv_layer_driver_pair_seq.sv
// conv_pair_seq: walks the (output k, tap j) pairs and selects img[k+j] / flt[j] for the stream.
module conv_pair_seq
  import conv_drv_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            step_i,
  input  logic [N_PIX-1:0][PIX_W-1:0]     img_i,
  input  logic [N_TAP-1:0][PIX_W-1:0]     flt_i,
  output logic [PIX_W-1:0]                pix_o,
  output logic [PIX_W-1:0]                tap_o
);

  localparam logic [2:0] KLast = 3'(N_OUT - 1);
  localparam logic [1:0] JLast = 2'(N_TAP - 1);

  logic [2:0] k_q;
  logic [1:0] j_q;

  // Wraps to (0,0) after the last pair so the next run starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      j_q <= '0;
    end else if (step_i) begin
      if (j_q == JLast) begin
        j_q <= '0;
        k_q <= (k_q == KLast) ? 3'd0 : k_q + 3'd1;
      end else begin
        j_q <= j_q + 2'd1;
      end
    end
  end

  always_comb begin
    pix_o = img_i[k_q + 3'(j_q)];
    tap_o = flt_i[j_q];
  end

endmodule

// File: rtl/conv_layer_driver.sv
// Drives one 1-D convolution (7 pixels x 3 taps -> 5 sums) through the CNN layer per go pulse.
// Define CONV_SELFCHECK_EN to add the res_err output and the internal expected-sum checker.
module conv_layer_driver
  import conv_drv_pkg::*;
#(
  parameter int unsigned RESULT_LAT = 2,
  parameter int unsigned GAP_CYC    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              img_wr_en,
  input  logic [2:0]        img_wr_addr,
  input  logic [PIX_W-1:0]  img_wr_data,
  input  logic              flt_wr_en,
  input  logic [1:0]        flt_wr_addr,
  input  logic [PIX_W-1:0]  flt_wr_data,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              Start,
  output logic [PIX_W-1:0]  Image,
  output logic [PIX_W-1:0]  Filter,
  output logic              ReadEn,
  input  logic [RES_W-1:0]  ConvResult,
  output logic              res_valid,
  output logic [2:0]        res_idx,
`ifdef CONV_SELFCHECK_EN
  output logic              res_err,
`endif
  output logic [RES_W-1:0]  res_data
);

  localparam logic [3:0] StreamLast = 4'(N_PROD - 1);
  localparam logic [3:0] GapLast    = 4'(GAP_CYC - 1);
  localparam logic [3:0] ReadLast   = 4'(N_OUT - 1);
  localparam logic [3:0] DrainLast  = 4'(RESULT_LAT - 1);
  localparam int unsigned Tap       = RESULT_LAT - 1;

  state_e                      state_q;
  logic [3:0]                  cnt_q;
  logic                        busy_q, done_q, start_q;
  logic [PIX_W-1:0]            image_q, filter_q;
  logic [N_PIX-1:0][PIX_W-1:0] img_q;
  logic [N_TAP-1:0][PIX_W-1:0] flt_q;
  logic [PIX_W-1:0]            pix, tap;
  logic                        step, go_acc, rd_next;
  logic [2:0]                  rd_idx_next;
  logic [RESULT_LAT-1:0]       vld_q;
  logic [RESULT_LAT-1:0][2:0]  idx_q;
  logic                        res_valid_q;
  logic [2:0]                  res_idx_q;
  logic [RES_W-1:0]            res_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q <= '0;
      flt_q <= '0;
    end else if (state_q == StIdle) begin
      if (img_wr_en && (img_wr_addr < 3'(N_PIX))) img_q[img_wr_addr] <= img_wr_data;
      if (flt_wr_en && (flt_wr_addr < 2'(N_TAP))) flt_q[flt_wr_addr] <= flt_wr_data;
    end
  end

  always_comb begin
    go_acc      = (state_q == StIdle) && go;
    step        = go_acc || ((state_q == StStream) && (cnt_q != StreamLast));
    rd_next     = 1'b0;
    rd_idx_next = 3'd0;
    if ((state_q == StGap) && (cnt_q == GapLast)) rd_next = 1'b1;
    if ((state_q == StRead) && (cnt_q != ReadLast)) begin
      rd_next     = 1'b1;
      rd_idx_next = cnt_q[2:0] + 3'd1;
    end
  end

  conv_pair_seq u_pair_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (step),
    .img_i  (img_q),
    .flt_i  (flt_q),
    .pix_o  (pix),
    .tap_o  (tap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      image_q  <= '0;
      filter_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            state_q  <= StStream;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            start_q  <= 1'b1;
            image_q  <= pix;
            filter_q <= tap;
          end
        end
        StStream: begin
          if (cnt_q == StreamLast) begin
            state_q  <= StGap;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            image_q  <= '0;
            filter_q <= '0;
          end else begin
            cnt_q    <= cnt_q + 4'd1;
            image_q  <= pix;
            filter_q <= tap;
          end
        end
        StGap: begin
          cnt_q <= (cnt_q == GapLast) ? 4'd0 : cnt_q + 4'd1;
          if (cnt_q == GapLast) state_q <= StRead;
        end
        StRead: begin
          cnt_q <= (cnt_q == ReadLast) ? 4'd0 : cnt_q + 4'd1;
          if (cnt_q == ReadLast) state_q <= StDrain;
        end
        StDrain: begin
          if (cnt_q == DrainLast) begin
            state_q <= StDone;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stage 0 is ReadEn itself; the last stage marks the cycle ConvResult is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q[0] <= rd_next;
      idx_q[0] <= rd_idx_next;
      for (int i = 1; i < RESULT_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= vld_q[Tap];
      if (vld_q[Tap]) begin
        res_idx_q  <= idx_q[Tap];
        res_data_q <= ConvResult;
      end
    end
  end

`ifdef CONV_SELFCHECK_EN
  logic [2:0]       chk_idx;
  logic [RES_W-1:0] chk_exp;
  logic             chk_bad;
  logic             res_err_q, err_seen_q;

  always_comb begin
    chk_idx = idx_q[Tap];
    chk_exp = exp_sum(img_q[chk_idx], img_q[chk_idx + 3'd1], img_q[chk_idx + 3'd2],
                      flt_q[0], flt_q[1], flt_q[2]);
    chk_bad = vld_q[Tap] && (ConvResult != chk_exp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_err_q  <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      res_err_q <= chk_bad;
      if (go_acc)       err_seen_q <= 1'b0;
      else if (chk_bad) err_seen_q <= 1'b1;
    end
  end

  assign res_err = res_err_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign Start     = start_q;
  assign Image     = image_q;
  assign Filter    = filter_q;
  assign ReadEn    = vld_q[0];
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_conv_layer_driver.sv
// Directed bench for conv_layer_driver: two instances (default and RESULT_LAT=3/GAP_CYC=2) each
// paired with a behavioural CNN layer model built from the streamed Image/Filter products.
module tb_conv_layer_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       img_wr_en = 1'b0, flt_wr_en = 1'b0, go = 1'b0, inj = 1'b0;
  logic [2:0] img_wr_addr = '0;
  logic [1:0] flt_wr_addr = '0;
  logic [3:0] img_wr_data = '0, flt_wr_data = '0;

  logic       start_s [2];
  logic [3:0] image_s [2];
  logic [3:0] filter_s[2];
  logic       readen_s[2];
  logic [9:0] conv_s  [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       rv_s    [2];
  logic [2:0] idx_s   [2];
  logic [9:0] data_s  [2];
  logic       err_s   [2];

  int         checks = 0;
  int         errors = 0;
  logic [3:0] img_sh[7];
  logic [3:0] flt_sh[3];
  logic [9:0] exp_res[5];
  int         err_idx = -1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 2 : 3;
    localparam int unsigned Gap = (g == 0) ? 1 : 2;

    conv_layer_driver #(.RESULT_LAT(Lat), .GAP_CYC(Gap)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .img_wr_en   (img_wr_en),
      .img_wr_addr (img_wr_addr),
      .img_wr_data (img_wr_data),
      .flt_wr_en   (flt_wr_en),
      .flt_wr_addr (flt_wr_addr),
      .flt_wr_data (flt_wr_data),
      .go          (go),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .Start       (start_s[g]),
      .Image       (image_s[g]),
      .Filter      (filter_s[g]),
      .ReadEn      (readen_s[g]),
      .ConvResult  (conv_s[g]),
      .res_valid   (rv_s[g]),
      .res_idx     (idx_s[g]),
`ifdef CONV_SELFCHECK_EN
      .res_err     (err_s[g]),
`endif
      .res_data    (data_s[g])
    );

`ifndef CONV_SELFCHECK_EN
    assign err_s[g] = 1'b0;
`endif

    // Layer model: stores 15 products, returns triple-sums Lat-1 edges after each ReadEn.
    logic [9:0] prod[15];
    logic [9:0] lp[Lat-1];
    int         wc, rc;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wc <= 0;
        rc <= 0;
        for (int i = 0; i < Lat - 1; i++) lp[i] <= '0;
      end else begin
        if (start_s[g]) begin
          prod[wc] <= 10'(image_s[g]) * 10'(filter_s[g]);
          wc <= (wc == 14) ? 0 : wc + 1;
        end
        if (readen_s[g]) begin
          lp[0] <= prod[3*rc] + prod[3*rc+1] + prod[3*rc+2] + ((inj && rc == 2) ? 10'd1 : 10'd0);
          rc <= (rc == 4) ? 0 : rc + 1;
        end else begin
          lp[0] <= '0;
        end
        for (int i = 1; i < Lat - 1; i++) lp[i] <= lp[i-1];
      end
    end

    assign conv_s[g] = lp[Lat-2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_img(input int a, input int d);
    img_wr_en = 1'b1; img_wr_addr = 3'(a); img_wr_data = 4'(d);
    tick();
    img_wr_en = 1'b0;
    if (a < 7) img_sh[a] = 4'(d);
  endtask

  task automatic wr_flt(input int a, input int d);
    flt_wr_en = 1'b1; flt_wr_addr = 2'(a); flt_wr_data = 4'(d);
    tick();
    flt_wr_en = 1'b0;
    if (a < 3) flt_sh[a] = 4'(d);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 7; i++) wr_img(i, i + 1);
    for (int i = 0; i < 3; i++) wr_flt(i, i + 1);
  endtask

  // Cycle numbers below count from the first Start cycle (sampled at negedge).
  task automatic run(input int abort_p);
    go = 1'b1;
    tick();
    go = 1'b0;
`ifdef CONV_SELFCHECK_EN
    chk("err_seen_clr", g_dut[0].u_dut.err_seen_q, 0);
`endif
    for (int p = 0; p < 15; p++) begin
      chk("stream_start0", start_s[0], 1);
      chk("stream_image0", image_s[0], img_sh[p/3 + p%3]);
      chk("stream_filter0", filter_s[0], flt_sh[p%3]);
      chk("stream_busy0", busy_s[0], 1);
      chk("stream_start1", start_s[1], 1);
      chk("stream_image1", image_s[1], img_sh[p/3 + p%3]);
      if (p == abort_p) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_start0", start_s[0], 0);
        chk("abort_start1", start_s[1], 0);
        chk("abort_busy0", busy_s[0], 0);
        chk("abort_image0", image_s[0], 0);
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      go = (p == 5);
      img_wr_en = (p == 8); img_wr_addr = 3'd0; img_wr_data = 4'd9;
      flt_wr_en = (p == 8); flt_wr_addr = 2'd0; flt_wr_data = 4'd9;
      tick();
    end
    go = 1'b0; img_wr_en = 1'b0; flt_wr_en = 1'b0;
    for (int cc = 15; cc <= 26; cc++) begin
      chk("rd_en0", readen_s[0], (cc >= 16 && cc <= 20));
      chk("rv0", rv_s[0], (cc >= 18 && cc <= 22));
      if (cc >= 18 && cc <= 22) begin
        chk("res_idx0", idx_s[0], cc - 18);
        chk("res_data0", data_s[0], exp_res[cc-18]);
`ifdef CONV_SELFCHECK_EN
        chk("res_err0", err_s[0], (cc - 18) == err_idx);
`endif
      end else begin
        chk("res_err0_idle", err_s[0], 0);
      end
      chk("done0", done_s[0], cc == 23);
      chk("busy0", busy_s[0], cc < 23);
      chk("start0_off", start_s[0], 0);
      chk("rd_en1", readen_s[1], (cc >= 17 && cc <= 21));
      chk("rv1", rv_s[1], (cc >= 20 && cc <= 24));
      if (cc >= 20 && cc <= 24) chk("res_data1", data_s[1], exp_res[cc-20]);
      chk("done1", done_s[1], cc == 25);
      chk("busy1", busy_s[1], cc < 25);
      go = (cc == 23);
      tick();
    end
    go = 1'b0;
    chk("end_busy0", busy_s[0], 0);
    chk("end_start0", start_s[0], 0);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", busy_s[0], 0);
    chk("rst_done", done_s[0], 0);
    chk("rst_start", start_s[0], 0);
    chk("rst_readen", readen_s[0], 0);
    chk("rst_rv", rv_s[0], 0);
    chk("rst_image", image_s[0], 0);
    chk("rst_filter", filter_s[0], 0);
    chk("rst_idx", idx_s[0], 0);
    chk("rst_data", data_s[0], 0);
    rst_n = 1'b1;
    tick();

    load_ramp();
    wr_img(7, 15);
    wr_flt(3, 15);
    exp_res = '{10'd14, 10'd20, 10'd26, 10'd32, 10'd38};
    run(-1);
    run(-1);

    run(7);
    chk("post_rst_busy", busy_s[0], 0);
    chk("post_rst_readen", readen_s[0], 0);
    load_ramp();
    run(-1);

    for (int i = 0; i < 7; i++) wr_img(i, 15);
    for (int i = 0; i < 3; i++) wr_flt(i, 15);
    exp_res = '{10'd675, 10'd675, 10'd675, 10'd675, 10'd675};
    run(-1);

`ifdef CONV_SELFCHECK_EN
    load_ramp();
    inj = 1'b1;
    err_idx = 2;
    exp_res = '{10'd14, 10'd20, 10'd27, 10'd32, 10'd38};
    run(-1);
    chk("err_seen_set", g_dut[0].u_dut.err_seen_q, 1);
    inj = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
